// File: rtl/issue_ctrl_if.sv
// Buffer-side link between the issue controller and the dual-slot
// instruction FIFO: read address and issue commands out, lookup results back.
interface issue_ctrl_if;
  logic [31:0] current_pc_o;
  logic        issue_o;
  logic        issue_mode_o;
  logic        buf_flush_o;
  logic [31:0] inst1_i;
  logic [31:0] inst2_i;
  logic        inst1_valid_i;
  logic        inst2_valid_i;

  modport master (
    output current_pc_o, issue_o, issue_mode_o, buf_flush_o,
    input  inst1_i, inst2_i, inst1_valid_i, inst2_valid_i
  );

  modport slave (
    input  current_pc_o, issue_o, issue_mode_o, buf_flush_o,
    output inst1_i, inst2_i, inst1_valid_i, inst2_valid_i
  );
endinterface

// File: rtl/issue_ctrl.sv
// Issue-stage controller: owns the buffer read pointer, picks single/dual/no
// issue from the two buffered instructions, and sequences taken branches
// (with MIPS delay slots), flushes and backend stalls.
module issue_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter bit          HILO_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  issue_ctrl_if.master ibuf,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] id_inst1_o,
  output logic [31:0] id_inst2_o,
  output logic [31:0] id_pc1_o,
  output logic [31:0] id_pc2_o,
  output logic        id_valid1_o,
  output logic        id_valid2_o
);

  localparam logic SINGLE_ISSUE = 1'b0;
  localparam logic DUAL_ISSUE   = 1'b1;

  typedef enum logic [1:0] {REFILL, RUN, DSLOT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_tgt;
  logic        pend_br;
  logic        buf_flush;
  logic        after_ds;

  logic        br1;
  logic        br2;
  logic [4:0]  dst1;
  logic        raw;
  logic        hilo;
  logic        issue;
  logic        dual;
  logic        apply;

  function automatic logic is_branch(input logic [31:0] inst);
    logic [5:0] op;
    logic [5:0] fn;
    op = inst[31:26];
    fn = inst[5:0];
    return (op == 6'b000001) || (op == 6'b000010) || (op == 6'b000011) ||
           (op[5:2] == 4'b0001) ||
           ((op == 6'b000000) && ((fn == 6'b001000) || (fn == 6'b001001)));
  endfunction

  function automatic logic [4:0] dest_reg(input logic [31:0] inst);
    logic [5:0] op;
    op = inst[31:26];
    if (op == 6'b000000)
      return inst[15:11];
    else if ((op == 6'b000011) || ((op == 6'b000001) && inst[20]))
      return 5'd31;
    else if ((op[5:3] == 3'b001) || (op[5:3] == 3'b100))
      return inst[20:16];
    else
      return 5'd0;
  endfunction

  // Hazard checks and the issue decision for the current buffer lookup.
  always_comb begin
    br1  = is_branch(ibuf.inst1_i);
    br2  = is_branch(ibuf.inst2_i);
    dst1 = dest_reg(ibuf.inst1_i);
    raw  = (dst1 != 5'd0) &&
           ((ibuf.inst2_i[25:21] == dst1) || (ibuf.inst2_i[20:16] == dst1));
    hilo = HILO_CHECK &&
           ((ibuf.inst1_i[5:2] == 4'b0110) ||
            ((ibuf.inst1_i[5:2] == 4'b0100) && ibuf.inst1_i[0])) &&
           (ibuf.inst2_i[5:2] == 4'b0100) && !ibuf.inst2_i[0];
    issue = ibuf.inst1_valid_i && !stall_i && !flush_i &&
            (state != REFILL) && !buf_flush;
    dual  = (state == RUN) && ibuf.inst1_valid_i && ibuf.inst2_valid_i &&
            !raw && !br2 && !hilo;
    // A pending redirect waits until the delay slot has gone; right after the
    // slot issues it takes effect even if the buffer offers more instructions.
    apply = pend_br && !stall_i &&
            (((state != DSLOT) && !issue) || after_ds);
  end

  // PC, state, pending-branch and flush-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= REFILL;
      pc        <= RESET_PC;
      pend_tgt  <= '0;
      pend_br   <= 1'b0;
      buf_flush <= 1'b0;
      after_ds  <= 1'b0;
    end else if (flush_i) begin
      state     <= REFILL;
      pc        <= flush_pc_i;
      pend_br   <= 1'b0;
      buf_flush <= 1'b1;
      after_ds  <= 1'b0;
    end else begin
      buf_flush <= apply;
      if (br_taken_i) begin
        pend_br  <= 1'b1;
        pend_tgt <= br_target_i;
      end else if (apply) begin
        pend_br <= 1'b0;
      end

      if (apply) begin
        pc       <= pend_tgt;
        state    <= REFILL;
        after_ds <= 1'b0;
      end else if (!stall_i) begin
        after_ds <= (state == DSLOT) && issue;
        if (issue)
          pc <= pc + (dual ? 32'd8 : 32'd4);
        case (state)
          REFILL:  if (ibuf.inst1_valid_i) state <= RUN;
          RUN:     if (issue && br1 && !dual) state <= DSLOT;
          DSLOT:   if (issue) state <= RUN;
          default: state <= REFILL;
        endcase
      end
    end
  end

  // Buffer-side and decode-side outputs.
  always_comb begin
    ibuf.current_pc_o = pc;
    ibuf.issue_o      = issue;
    ibuf.issue_mode_o = dual ? DUAL_ISSUE : SINGLE_ISSUE;
    ibuf.buf_flush_o  = buf_flush;
    id_valid1_o       = issue;
    id_valid2_o       = issue && dual;
    id_inst1_o        = issue ? ibuf.inst1_i : '0;
    id_pc1_o          = issue ? pc : '0;
    id_inst2_o        = (issue && dual) ? ibuf.inst2_i : '0;
    id_pc2_o          = (issue && dual) ? (pc + 32'd4) : '0;
  end

endmodule
